// File: rtl/board_tile_sequencer_if.sv
// board_tile_sequencer_if
//  Tile record channel between the board tile sequencer and the draw engine.
//  The sequencer is the master: it drives tile_valid and the payload, and the
//  draw engine (slave) returns tile_ready. A record moves when tile_valid and
//  tile_ready are both high at a clock edge.
//  Signals:
//   tile_valid  master->slave  record valid
//   tile_ready  slave->master  draw engine accepts record
//   tile_xpos   master->slave  tile top-left x (POS_W)
//   tile_ypos   master->slave  tile top-left y (POS_W)
//   tile_size   master->slave  tile edge length (SIZE_W)
//   tile_col    master->slave  column index (IDX_W)
//   tile_row    master->slave  row index (IDX_W)
//   tile_last   master->slave  final record of the pass
interface board_tile_sequencer_if #(
    parameter int POS_W  = 11,
    parameter int SIZE_W = 7,
    parameter int IDX_W  = 5
);
    logic              tile_valid;
    logic              tile_ready;
    logic [POS_W-1:0]  tile_xpos;
    logic [POS_W-1:0]  tile_ypos;
    logic [SIZE_W-1:0] tile_size;
    logic [IDX_W-1:0]  tile_col;
    logic [IDX_W-1:0]  tile_row;
    logic              tile_last;

    modport master (
        output tile_valid, tile_xpos, tile_ypos, tile_size,
               tile_col, tile_row, tile_last,
        input  tile_ready
    );

    modport slave (
        input  tile_valid, tile_xpos, tile_ypos, tile_size,
               tile_col, tile_row, tile_last,
        output tile_ready
    );
endinterface

// File: rtl/board_tile_sequencer.sv
// board_tile_sequencer
//  Raster sequencer for the game board. A start pulse latches the board
//  geometry and walks a rows x cols grid in row-major order, emitting one tile
//  record per tile on a valid/ready channel. Tile positions are produced by
//  incremental addition of the pitch (tile size + GAP), so no multiplier is used.
//  Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          latch config and begin a pass (IDLE/DONE only)
//   abort          terminate the pass, return to IDLE, no done pulse
//   board_xpos/ypos, button_size, cols, rows   pass configuration
//   tile           board_tile_sequencer_if master modport (record channel)
//   busy           high while issuing records
//   done           one-cycle pulse after the final record transfers
//  Build option:
//   BOARD_SEQ_CONTINUOUS_EN  when defined, each completed pass is followed by
//   a single dead cycle and then an automatic restart with the current config,
//   until abort or rst. An empty grid in this mode parks the block in IDLE.
module board_tile_sequencer #(
    parameter int MAX_COLS = 16,
    parameter int MAX_ROWS = 16,
    parameter int POS_W    = 11,
    parameter int SIZE_W   = 7,
    parameter int IDX_W    = 5,
    parameter int GAP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [POS_W-1:0]  board_xpos,
    input  logic [POS_W-1:0]  board_ypos,
    input  logic [SIZE_W-1:0] button_size,
    input  logic [IDX_W-1:0]  cols,
    input  logic [IDX_W-1:0]  rows,
    board_tile_sequencer_if.master tile,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  col_q, col_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic [POS_W-1:0]  x_q, x_d;
    logic [POS_W-1:0]  y_q, y_d;
    logic [IDX_W-1:0]  cols_l_q, cols_l_d;
    logic [IDX_W-1:0]  rows_l_q, rows_l_d;
    logic [POS_W-1:0]  pitch_q, pitch_d;
    logic [POS_W-1:0]  board_x_l_q, board_x_l_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Clamped view of the live configuration inputs, used only at latch time.
    logic [IDX_W-1:0]  cols_c;
    logic [IDX_W-1:0]  rows_c;
    logic              cfg_empty_c;

    always_comb begin
        cols_c      = (cols > IDX_W'(MAX_COLS)) ? IDX_W'(MAX_COLS) : cols;
        rows_c      = (rows > IDX_W'(MAX_ROWS)) ? IDX_W'(MAX_ROWS) : rows;
        cfg_empty_c = (cols_c == '0) || (rows_c == '0);
    end

    // Next-state and datapath. load_c marks "latch config and present tile
    // (0,0)"; abort is applied last so it overrides every other decision.
    logic              load_c;
    logic [IDX_W-1:0]  col_nx;
    logic [IDX_W-1:0]  row_nx;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        x_d         = x_q;
        y_d         = y_q;
        cols_l_d    = cols_l_q;
        rows_l_d    = rows_l_q;
        pitch_d     = pitch_q;
        board_x_l_d = board_x_l_q;
        size_d      = size_q;
        valid_d     = valid_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_c      = 1'b0;
        col_nx      = col_q;
        row_nx      = row_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_empty_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        load_c = 1'b1;
                    end
                end
            end

            ISSUE: begin
                if (valid_q && tile.tile_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Row wrap reloads x from the latched board origin.
                        if (col_q == cols_l_q - IDX_W'(1)) begin
                            col_nx = '0;
                            row_nx = row_q + IDX_W'(1);
                            x_d    = board_x_l_q;
                            y_d    = y_q + pitch_q;
                        end else begin
                            col_nx = col_q + IDX_W'(1);
                            row_nx = row_q;
                            x_d    = x_q + pitch_q;
                        end
                        col_d  = col_nx;
                        row_d  = row_nx;
                        last_d = (col_nx == cols_l_q - IDX_W'(1)) &&
                                 (row_nx == rows_l_q - IDX_W'(1));
                    end
                end
            end

            DONE: begin
`ifdef BOARD_SEQ_CONTINUOUS_EN
                // Automatic restart with whatever config is present now.
                if (cfg_empty_c) begin
                    state_d = IDLE;
                end else begin
                    load_c = 1'b1;
                end
`else
                if (start) begin
                    if (cfg_empty_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        load_c = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
`endif
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        if (load_c) begin
            state_d     = ISSUE;
            cols_l_d    = cols_c;
            rows_l_d    = rows_c;
            pitch_d     = POS_W'(button_size) + POS_W'(GAP);
            board_x_l_d = board_xpos;
            size_d      = button_size;
            col_d       = '0;
            row_d       = '0;
            x_d         = board_xpos;
            y_d         = board_ypos;
            valid_d     = 1'b1;
            busy_d      = 1'b1;
            last_d      = (cols_c == IDX_W'(1)) && (rows_c == IDX_W'(1));
        end

        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cols_l_q    <= '0;
            rows_l_q    <= '0;
            pitch_q     <= '0;
            board_x_l_q <= '0;
            size_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cols_l_q    <= cols_l_d;
            rows_l_q    <= rows_l_d;
            pitch_q     <= pitch_d;
            board_x_l_q <= board_x_l_d;
            size_q      <= size_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tile.tile_valid = valid_q;
    assign tile.tile_xpos  = x_q;
    assign tile.tile_ypos  = y_q;
    assign tile.tile_size  = size_q;
    assign tile.tile_col   = col_q;
    assign tile.tile_row   = row_q;
    assign tile.tile_last  = last_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_board_tile_sequencer.sv
// tb_board_tile_sequencer
//  Directed bench for board_tile_sequencer (GAP=2, 16x16 max grid). Inputs are
//  driven 1ns after each rising edge and outputs are sampled at the same point,
//  so every value seen reflects the state registered at the previous edge.
//  Built with BOARD_SEQ_CONTINUOUS_EN it exercises the auto-restart mode instead
//  of the single-pass scenarios.
module tb_board_tile_sequencer;

    localparam int POS_W  = 11;
    localparam int SIZE_W = 7;
    localparam int IDX_W  = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [POS_W-1:0]  board_xpos;
    logic [POS_W-1:0]  board_ypos;
    logic [SIZE_W-1:0] button_size;
    logic [IDX_W-1:0]  cols;
    logic [IDX_W-1:0]  rows;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    board_tile_sequencer_if #(.POS_W(POS_W), .SIZE_W(SIZE_W), .IDX_W(IDX_W)) tif ();

    board_tile_sequencer #(
        .MAX_COLS (16),
        .MAX_ROWS (16),
        .POS_W    (POS_W),
        .SIZE_W   (SIZE_W),
        .IDX_W    (IDX_W),
        .GAP      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .board_xpos  (board_xpos),
        .board_ypos  (board_ypos),
        .button_size (button_size),
        .cols        (cols),
        .rows        (rows),
        .tile        (tif.master),
        .busy        (busy),
        .done        (done)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Advance one clock and settle 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Load a configuration and pulse start for one edge.
    task automatic applyStimulus(input int bx, input int by, input int sz,
                                 input int c, input int r);
        board_xpos  = POS_W'(bx);
        board_ypos  = POS_W'(by);
        button_size = SIZE_W'(sz);
        cols        = IDX_W'(c);
        rows        = IDX_W'(r);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Check the presented record against the expected tile.
    task automatic checkTile(input string tag, input int x, input int y,
                             input int c, input int r, input int last);
        checkOutput({tag, ".valid"}, 32'(tif.tile_valid), 1);
        checkOutput({tag, ".x"},     32'(tif.tile_xpos),  x);
        checkOutput({tag, ".y"},     32'(tif.tile_ypos),  y);
        checkOutput({tag, ".col"},   32'(tif.tile_col),   c);
        checkOutput({tag, ".row"},   32'(tif.tile_row),   r);
        checkOutput({tag, ".last"},  32'(tif.tile_last),  last);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        board_xpos     = '0;
        board_ypos     = '0;
        button_size    = '0;
        cols           = '0;
        rows           = '0;
        tif.tile_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        checkOutput("reset.valid", 32'(tif.tile_valid), 0);
        checkOutput("reset.x",     32'(tif.tile_xpos),  0);
        checkOutput("reset.size",  32'(tif.tile_size),  0);
        checkOutput("reset.last",  32'(tif.tile_last),  0);
        checkOutput("reset.busy",  32'(busy),           0);
        checkOutput("reset.done",  32'(done),           0);

`ifdef BOARD_SEQ_CONTINUOUS_EN
        // 2x2 at (10,20), size 20, pitch 22: passes repeat until abort.
        applyStimulus(10, 20, 20, 2, 2);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                checkTile($sformatf("cont.p%0d.t%0d", p, i),
                          10 + 22 * (i % 2), 20 + 22 * (i / 2), i % 2, i / 2,
                          (i == 3) ? 1 : 0);
                tick();
            end
            checkOutput($sformatf("cont.p%0d.done", p),  32'(done),           1);
            checkOutput($sformatf("cont.p%0d.dead", p),  32'(tif.tile_valid), 0);
            tick();
            checkOutput($sformatf("cont.p%0d.rdone", p), 32'(done),           0);
        end
        checkTile("cont.p2.t0", 10, 20, 0, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("cont.abort.valid", 32'(tif.tile_valid), 0);
        checkOutput("cont.abort.busy",  32'(busy),           0);
        tick();
        checkOutput("cont.abort.stay",  32'(tif.tile_valid), 0);
        checkOutput("cont.abort.done",  32'(done),           0);
`else
        // Scenario 1: 3x2 at (100,50), size 20, pitch 22, always ready.
        applyStimulus(100, 50, 20, 3, 2);
        checkOutput("t1.size", 32'(tif.tile_size), 20);
        checkOutput("t1.busy", 32'(busy),          1);
        for (int i = 0; i < 6; i++) begin
            checkTile($sformatf("t1.tile%0d", i), 100 + 22 * (i % 3),
                      50 + 22 * (i / 3), i % 3, i / 3, (i == 5) ? 1 : 0);
            checkOutput($sformatf("t1.done%0d", i), 32'(done), 0);
            tick();
        end
        checkOutput("t1.end.valid", 32'(tif.tile_valid), 0);
        checkOutput("t1.end.done",  32'(done),           1);
        checkOutput("t1.end.busy",  32'(busy),           0);
        tick();
        checkOutput("t1.post.done", 32'(done),           0);

        // Scenario 2: same pass with a 3-cycle stall on tile (1,0).
        applyStimulus(100, 50, 20, 3, 2);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                tif.tile_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    checkTile($sformatf("t2.stall%0d", s), 122, 50, 1, 0, 0);
                    tick();
                end
                tif.tile_ready = 1'b1;
            end
            checkTile($sformatf("t2.tile%0d", i), 100 + 22 * (i % 3),
                      50 + 22 * (i / 3), i % 3, i / 3, (i == 5) ? 1 : 0);
            tick();
        end
        checkOutput("t2.end.done", 32'(done), 1);
        tick();

        // Scenario 3: zero columns gives no records, just a done pulse.
        applyStimulus(100, 50, 20, 0, 4);
        checkOutput("t3.valid", 32'(tif.tile_valid), 0);
        checkOutput("t3.busy",  32'(busy),           0);
        checkOutput("t3.done",  32'(done),           1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t3.after%0d.valid", i), 32'(tif.tile_valid), 0);
            checkOutput($sformatf("t3.after%0d.done", i),  32'(done),           0);
        end

        // Scenario 4: cols=20 clamps to 16, origin (0,0), pitch 22.
        applyStimulus(0, 0, 20, 20, 1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t4.col%0d", i),  32'(tif.tile_col),  i);
            checkOutput($sformatf("t4.x%0d", i),    32'(tif.tile_xpos), 22 * i);
            checkOutput($sformatf("t4.last%0d", i), 32'(tif.tile_last), (i == 15) ? 1 : 0);
            tick();
        end
        checkOutput("t4.end.valid", 32'(tif.tile_valid), 0);
        checkOutput("t4.end.done",  32'(done),           1);
        tick();

        // Scenario 5: abort after two transfers of a 3x3 pass, then restart.
        applyStimulus(30, 40, 10, 3, 3);
        tick();
        tick();
        checkTile("t5.pre", 54, 40, 2, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t5.abort.valid", 32'(tif.tile_valid), 0);
        checkOutput("t5.abort.busy",  32'(busy),           0);
        checkOutput("t5.abort.done",  32'(done),           0);
        tick();
        checkOutput("t5.idle.done",   32'(done),           0);
        checkOutput("t5.idle.valid",  32'(tif.tile_valid), 0);
        applyStimulus(30, 40, 10, 3, 3);
        checkTile("t5.restart", 30, 40, 0, 0, 0);

        // Start during a pass is ignored; the walk continues normally.
        start = 1'b1;
        board_xpos = POS_W'(500);
        tick();
        start = 1'b0;
        checkTile("t5.ignstart", 42, 40, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Single tile: first record is also the last.
        applyStimulus(7, 9, 5, 1, 1);
        checkTile("t6.single", 7, 9, 0, 0, 1);
        tick();
        checkOutput("t6.done",  32'(done),           1);
        checkOutput("t6.valid", 32'(tif.tile_valid), 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
